uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 39 +++
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the transmit and receive paths.
// Optional even-parity framing is selected in uart_tx with UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last sysclk cycle of each bit slot.
// Shared between the UART transmitter and receiver.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] count_r;

  // Terminal-count decode of the bit timer.
  always_comb begin
    bit_tick = en && (count_r == CNT_W'(CLKS_PER_BIT - 1));
  end

  // Bit timer; clr re-aligns the phase to the start of a new frame.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      if (bit_tick) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Double-buffered 8N1 UART transmitter (shift register plus one holding register).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 UART_TX
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_e          state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] hold_r;
  logic                 hold_valid_r;
  logic [BIT_W-1:0]     bit_idx_r;

  logic                 bit_tick_s;
  logic                 baud_clr_s;
  logic                 baud_en_s;
  logic                 stop_tick_s;
  logic                 start_frame_s;
  logic                 hold_load_s;
  logic [DATA_BITS-1:0] frame_data_s;

`ifdef UART_TX_PARITY_EN
  logic parity_r;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction
`endif

  // Launch, capture and baud-control decode; a held byte has priority over a new request.
  always_comb begin
    stop_tick_s   = (state_r == STOP) && bit_tick_s;
    start_frame_s = ((state_r == IDLE) && tx_start) ||
                    (stop_tick_s && (hold_valid_r || tx_start));
    hold_load_s   = tx_start && tx_ready && (state_r != IDLE) && !stop_tick_s;
    frame_data_s  = hold_valid_r ? hold_r : tx_data;
    baud_clr_s    = (state_r == IDLE) && tx_start;
    baud_en_s     = (state_r != IDLE);
  end

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .sysclk   (sysclk),
    .reset    (reset),
    .clr      (baud_clr_s),
    .en       (baud_en_s),
    .bit_tick (bit_tick_s)
  );

  // Frame sequencer, holding register and registered line/status outputs.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_r      <= IDLE;
      shift_r      <= '0;
      hold_r       <= '0;
      hold_valid_r <= 1'b0;
      bit_idx_r    <= '0;
      tx_ready     <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      UART_TX      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else begin
      tx_done <= stop_tick_s;

      if (hold_load_s) begin
        hold_r       <= tx_data;
        hold_valid_r <= 1'b1;
        tx_ready     <= 1'b0;
      end else if (stop_tick_s && hold_valid_r) begin
        hold_valid_r <= 1'b0;
        tx_ready     <= 1'b1;
      end

      if (start_frame_s) begin
        state_r   <= START;
        shift_r   <= frame_data_s;
        bit_idx_r <= '0;
        tx_busy   <= 1'b1;
        UART_TX   <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_r  <= even_parity(frame_data_s);
`endif
      end else if (bit_tick_s) begin
        case (state_r)
          START: begin
            state_r <= DATA;
            UART_TX <= shift_r[0];
          end
          DATA: begin
            if (bit_idx_r == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_r <= PARITY;
              UART_TX <= parity_r;
`else
              state_r <= STOP;
              UART_TX <= 1'b1;
`endif
            end else begin
              shift_r   <= shift_r >> 1;
              UART_TX   <= shift_r[1];
              bit_idx_r <= bit_idx_r + BIT_W'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state_r <= STOP;
            UART_TX <= 1'b1;
          end
`endif
          STOP: begin
            state_r <= IDLE;
            tx_busy <= 1'b0;
            UART_TX <= 1'b1;
          end
          default: begin
            state_r <= IDLE;
            tx_busy <= 1'b0;
            UART_TX <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a frame-level timing model predicts status outputs
// and accepted bytes; a serial monitor decodes the line and checks the bytes in order.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic       sysclk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       UART_TX;

  int tests = 0;
  int fails = 0;

  // Reference model state: cycles left in the frame on the line, holding slot, done pulse.
  int         rem_m     = 0;
  bit         hold_m    = 1'b0;
  bit         done_m    = 1'b0;
  bit         acc_m     = 1'b0;
  int         reset_cnt = 0;
  bit         chk_en    = 1'b0;
  logic [7:0] exp_q[$];

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .UART_TX  (UART_TX)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 25) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Model: a frame occupies the line for FRAME cycles; one extra byte may wait in the slot.
  always @(posedge sysclk) begin
    if (!reset) begin
      rem_m  = 0;
      hold_m = 1'b0;
      done_m = 1'b0;
      exp_q.delete();
      reset_cnt++;
    end else begin
      acc_m  = tx_start && !hold_m;
      if (acc_m) exp_q.push_back(tx_data);
      done_m = 1'b0;
      if (rem_m > 0) begin
        rem_m--;
        if (rem_m == 0) begin
          done_m = 1'b1;
          if (hold_m) begin
            hold_m = 1'b0;
            rem_m  = FRAME;
          end
        end
      end
      if (acc_m) begin
        if (rem_m == 0) rem_m = FRAME;
        else hold_m = 1'b1;
      end
    end
  end

  // Per-cycle status checks against the model.
  always @(negedge sysclk) begin
    if (chk_en) begin
      check("tx_ready", {31'd0, tx_ready}, {31'd0, !hold_m});
      check("tx_busy", {31'd0, tx_busy}, {31'd0, rem_m != 0});
      check("tx_done", {31'd0, tx_done}, {31'd0, done_m});
      if (rem_m == 0) check("idle_line", {31'd0, UART_TX}, 32'd1);
    end
  end

  task automatic mon_wait(input int n, input int rc, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      if (reset_cnt != rc) ab = 1'b1;
    end
  endtask

  // Serial monitor: find a start bit, sample every bit mid-slot, compare with the queue head.
  initial begin : monitor
    int         rc;
    bit         ab;
    logic [7:0] b;
    logic [7:0] e;
    logic       pbit;
    forever begin
      @(negedge sysclk);
      if (chk_en && reset && UART_TX === 1'b0) begin
        rc   = reset_cnt;
        ab   = 1'b0;
        b    = 8'h00;
        pbit = 1'b0;
        mon_wait(CPB / 2, rc, ab);
        if (!ab) check("start_bit", {31'd0, UART_TX}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB, rc, ab);
          b[i] = UART_TX;
        end
`ifdef UART_TX_PARITY_EN
        mon_wait(CPB, rc, ab);
        pbit = UART_TX;
`endif
        mon_wait(CPB, rc, ab);
        if (!ab) begin
          check("stop_bit", {31'd0, UART_TX}, 32'd1);
          check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("payload", {24'd0, b}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
            check("parity_bit", {31'd0, pbit}, {31'd0, ^e});
`endif
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input int len);
    tx_data  = d;
    tx_start = 1'b1;
    repeat (len) @(negedge sysclk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rem_m != 0 || hold_m || exp_q.size() != 0) && n < 4 * FRAME) begin
      @(negedge sysclk);
      n++;
    end
    check("drain_timeout", {31'd0, n < 4 * FRAME}, 32'd1);
    repeat (4) @(negedge sysclk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    reset    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check("reset_line", {31'd0, UART_TX}, 32'd1);
    check("reset_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_done", {31'd0, tx_done}, 32'd0);
    chk_en = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge sysclk);

    // Single byte: start bit visible right after the accepting edge.
    send(8'h18, 1);
    check("single_start_low", {31'd0, UART_TX}, 32'd0);
    wait_idle();

    // Back-to-back: second byte held, no gap between frames.
    send(8'h18, 1);
    send(8'h78, 1);
    check("ready_after_hold", {31'd0, tx_ready}, 32'd0);
    wait_idle();

    // Overflow: third request while the slot is full is dropped.
    send(8'h18, 1);
    send(8'h78, 1);
    send(8'hFF, 1);
    wait_idle();

    // Reset during data bit 3 with a byte held: nothing else goes out.
    send(8'h18, 1);
    send(8'h78, 1);
    repeat (4 * CPB) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    check("midreset_line", {31'd0, UART_TX}, 32'd1);
    check("midreset_ready", {31'd0, tx_ready}, 32'd1);
    check("midreset_busy", {31'd0, tx_busy}, 32'd0);
    reset = 1'b1;
    repeat (3 * FRAME) @(negedge sysclk);

`ifdef UART_TX_PARITY_EN
    send(8'h18, 1);
    wait_idle();
    send(8'h07, 1);
    wait_idle();
`endif

    // Random traffic, including requests landing on the final stop cycle.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, FRAME + 20)) @(negedge sysclk);
      send(8'($urandom), int'($urandom_range(1, 3)));
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
